if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction fetch stage that consumes the current PC register value and drives the PC's next value. It issues word reads to instruction memory over a valid/ready request channel and captures the responses into a small instruction buffer. It presents (pc, instruction) pairs to the IF/ID boundary with a valid/ready handshake. It sits between the PC register, the instruction memory port and the decode stage, and absorbs branch/jump redirects from execute.

## Interface
- DEPTH, 2, instruction buffer entries (power of two, ≥2)
- XLEN, 32, address/data width

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_value  in  XLEN  current PC from the PC register
- next_pc_out  out  XLEN  value the PC register loads next cycle
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address, always equals pc_value
- imem_resp_valid  in  1  read data valid, one pulse per accepted request
- imem_resp_data  in  32  instruction word
- redirect_valid  in  1  branch/jump taken, flush and refetch
- redirect_pc  in  XLEN  redirect target
- id_valid  out  1  buffer head valid
- id_ready  in  1  decode accepts head
- id_pc  out  XLEN  PC of head instruction
- id_instr  out  32  head instruction
- fetch_fault  out  1  misaligned redirect latched (see Configuration)

## Operation
- At most one outstanding memory request.
- FSM states: IDLE, WAIT, DROP.
- IDLE, issue condition:
  - imem_req_valid = !rst && !redirect_valid && count < DEPTH && !fetch_fault.
  - On valid && ready: latch req_pc = pc_value, go WAIT.
- WAIT:
  - On imem_resp_valid: push {req_pc, imem_resp_data}, go IDLE.
  - No request is issued while in WAIT.
- DROP:
  - On imem_resp_valid: discard the data, go IDLE.
- next_pc_out, combinational, in priority order:
  - redirect_valid: redirect_pc.
  - Request handshake this cycle: pc_value + 4, modulo 2^XLEN (0xFFFFFFFC wraps to 0).
  - Otherwise: pc_value (hold).
- Redirect, any state:
  - Buffer is flushed (count = 0).
  - WAIT without resp_valid: go DROP.
  - WAIT with resp_valid: the response is dropped, go IDLE.
  - DROP without resp_valid: stay in DROP.
  - DROP with resp_valid: go IDLE.
  - No request is issued in the redirect cycle.
- Buffer:
  - Circular FIFO with first-word fall-through; id_valid = (count != 0).
  - Pop on id_valid && id_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - Overflow is impossible: a request is issued only when count < DEPTH, and nothing else pushes.
  - A redirect overrides both push and pop in the same cycle.
- id_pc and id_instr hold stable while id_valid && !id_ready.

## Timing
- Reset values:
  - Internal: state IDLE, count 0, pointers 0.
  - Outputs: fetch_fault 0, id_valid 0, imem_req_valid 0.
  - next_pc_out = pc_value during rst. The PC register resets to 0 itself.
- Request accepted at cycle T, response at T+k (k≥1):
  - id_valid rises at T+k+1.
  - The earliest next request is issued at T+k+1.
- Back-to-back fetch with k=1 gives one instruction every 2 cycles.
- Redirect at cycle R: pc_value = redirect_pc at R+1, and that address is requested at R+1 if in IDLE.
- id_valid drops the cycle after a redirect.
- rst mid-WAIT: the outstanding response is not tracked. The memory is reset by the same rst and produces no response.

## Configuration
- FETCH_MISALIGN_CHK_EN defined:
  - redirect_valid with redirect_pc[1:0] != 0 sets fetch_fault the next cycle.
  - Fetching stops while fetch_fault is set.
  - The next aligned redirect clears fetch_fault and resumes fetching.
- FETCH_MISALIGN_CHK_EN undefined:
  - fetch_fault is tied 0.
  - next_pc_out uses redirect_pc with bits [1:0] forced to 0.

## Test plan
- Reset then free-run, memory k=1, id_ready=1 -> id_pc sequence 0x0, 0x4, 0x8 with matching data, one instruction every 2 cycles.
- id_ready=0 for 10 cycles -> exactly DEPTH=2 entries buffered, then no request; next_pc_out holds 0x8. Release id_ready -> fetch resumes at 0x8.
- Redirect to 0x100 while in WAIT, response arrives 3 cycles later -> the stale word is dropped, next id_pc is 0x100, and no 0x4 entry appears.
- Redirect coincident with resp_valid and id_ready -> the buffer empties, no pop is reported, and the following fetch address is redirect_pc.
- pc_value = 0xFFFFFFFC on request accept -> next_pc_out = 0x00000000.
- With FETCH_MISALIGN_CHK_EN, redirect to 0x102:
  - fetch_fault = 1 and imem_req_valid stays 0.
  - A redirect to 0x200 clears the fault and fetches 0x200.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: one outstanding imem read, small FWFT buffer.
// Optional misaligned-redirect fault: define FETCH_MISALIGN_CHK_EN.
module if_fetch_unit #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_value,
  output logic [XLEN-1:0] next_pc_out,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic            fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [31:0]     ins_mem [DEPTH];

  logic            fault;
  logic [XLEN-1:0] redir_tgt;
  logic            req_fire;
  logic            push;
  logic            pop;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q, fault_d;

  assign redir_tgt = redirect_pc;
  assign fault     = fault_q;

  // Misaligned redirect raises the fault; the next redirect re-evaluates it.
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid)
      fault_d = (redirect_pc[1:0] != 2'b00);
  end

  // Fault flag register.
  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
`else
  assign redir_tgt = redirect_pc & ~XLEN'(3);
  assign fault     = 1'b0;
`endif

  assign fetch_fault   = fault;
  assign imem_req_addr = pc_value;
  assign id_valid      = (count_q != '0);
  assign id_pc         = pc_mem[rd_ptr_q];
  assign id_instr      = ins_mem[rd_ptr_q];

  // Request issue and buffer push/pop qualifiers; redirect blocks all three.
  always_comb begin
    imem_req_valid = !rst && !redirect_valid && (state_q == IDLE)
                     && (count_q < CW'(DEPTH)) && !fault;
    req_fire = imem_req_valid && imem_req_ready;
    push     = (state_q == WAIT) && imem_resp_valid && !redirect_valid;
    pop      = id_valid && id_ready && !redirect_valid;
  end

  // Next PC: redirect wins, then sequential advance on request accept.
  always_comb begin
    next_pc_out = pc_value;
    if (!rst) begin
      if (redirect_valid)
        next_pc_out = redir_tgt;
      else if (req_fire)
        next_pc_out = pc_value + XLEN'(4);
    end
  end

  // Fetch FSM next state: DROP swallows a response orphaned by a redirect.
  always_comb begin
    state_d  = state_q;
    req_pc_d = req_pc_q;
    unique case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d  = WAIT;
          req_pc_d = pc_value;
        end
      end
      WAIT: begin
        if (redirect_valid)
          state_d = imem_resp_valid ? IDLE : DROP;
        else if (imem_resp_valid)
          state_d = IDLE;
      end
      DROP: begin
        if (imem_resp_valid)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Buffer pointer and occupancy update; redirect flushes everything.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect_valid) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Buffer storage, written on push only.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= req_pc_q;
      ins_mem[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: PC register, latency memory,
// queue-based reference model and directed scenarios.
module tb_if_fetch_unit;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_value;
  logic [31:0] next_pc_out;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b1;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        fetch_fault;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int nfire  = 0;
  int mem_k  = 1;

  if_fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk),
    .rst(rst),
    .pc_value(pc_value),
    .next_pc_out(next_pc_out),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_pc(id_pc),
    .id_instr(id_instr),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return a ^ 32'h5A3C_0F13;
  endfunction

  // PC register
  always @(posedge clk) pc_value <= rst ? 32'h0 : next_pc_out;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory with mem_k cycles of latency
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;
  always @(posedge clk) begin
    if (rst) begin
      m_busy          <= 1'b0;
      m_cnt           <= 0;
      imem_resp_valid <= 1'b0;
    end else begin
      imem_resp_valid <= 1'b0;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= mem_word(m_addr);
          m_busy          <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        if (mem_k <= 1) begin
          imem_resp_valid <= 1'b1;
          imem_resp_data  <= mem_word(imem_req_addr);
        end else begin
          m_busy <= 1'b1;
          m_addr <= imem_req_addr;
          m_cnt  <= mem_k - 1;
        end
      end
    end
  end

  // Reference model: fetched entries queue plus one pending fetch record
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend  = 0;
  bit          m_drop  = 0;
  bit          m_fault = 0;
  logic [31:0] m_pc;

  function automatic bit exp_req();
    return !rst && !redirect_valid && !m_pend
           && (mq.size() < DEPTH) && !m_fault;
  endfunction

  function automatic logic [31:0] exp_next();
    if (rst) return pc_value;
    if (redirect_valid) begin
`ifdef FETCH_MISALIGN_CHK_EN
      return redirect_pc;
`else
      return {redirect_pc[31:2], 2'b00};
`endif
    end
    if (exp_req() && imem_req_ready) return pc_value + 32'd4;
    return pc_value;
  endfunction

  always @(posedge clk) begin : model
    bit fire;
    fire = exp_req() && imem_req_ready;
    if (rst) begin
      mq.delete();
      m_pend  = 0;
      m_drop  = 0;
      m_fault = 0;
    end else if (redirect_valid) begin
      mq.delete();
      if (m_pend && imem_resp_valid) begin
        m_pend = 0;
        m_drop = 0;
      end else if (m_pend) begin
        m_drop = 1;
      end
`ifdef FETCH_MISALIGN_CHK_EN
      m_fault = (redirect_pc[1:0] != 2'b00);
`endif
    end else begin
      if (mq.size() > 0 && id_ready) void'(mq.pop_front());
      if (m_pend && imem_resp_valid) begin
        if (!m_drop) mq.push_back('{m_pc, imem_resp_data});
        m_pend = 0;
        m_drop = 0;
      end
      if (fire) begin
        m_pend = 1;
        m_drop = 0;
        m_pc   = pc_value;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!rst) begin
      check("req_valid", imem_req_valid, exp_req());
      check("req_addr", imem_req_addr, pc_value);
      check("next_pc", next_pc_out, exp_next());
      check("id_valid", id_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        check("id_pc", id_pc, mq[0].pc);
        check("id_instr", id_instr, mq[0].ins);
      end
      check("fetch_fault", fetch_fault, m_fault);
    end
  end

  // Log of accepted (non-flushed) decode handshakes
  logic [31:0] seen[$];
  logic [31:0] seen_ins[$];
  int          seen_cyc[$];
  always @(posedge clk) begin
    if (!rst && id_valid && id_ready && !redirect_valid) begin
      seen.push_back(id_pc);
      seen_ins.push_back(id_instr);
      seen_cyc.push_back(cyc);
    end
    if (!rst && imem_req_valid && imem_req_ready) nfire++;
  end

  function automatic logic [31:0] sp(int i);
    return (i < seen.size()) ? seen[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] si(int i);
    return (i < seen_ins.size()) ? seen_ins[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int sc(int i);
    return (i < seen_cyc.size()) ? seen_cyc[i] : -1000;
  endfunction

  function automatic int n_low();
    int n = 0;
    foreach (seen[i]) if (seen[i] < 32'h100) n++;
    return n;
  endfunction

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int k);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    imem_req_ready = 1'b1;
    mem_k          = k;
    step(2);
    seen.delete();
    seen_ins.delete();
    seen_cyc.delete();
    nfire = 0;
    rst   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    // reset state, redirect ignored while in reset
    rst            = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step(2);
    @(negedge clk);
    check("rst id_valid", id_valid, 32'h0);
    check("rst req_valid", imem_req_valid, 32'h0);
    check("rst fault", fetch_fault, 32'h0);
    check("rst next_pc", next_pc_out, 32'h0);

    // free run, k=1
    do_reset(1);
    step(12);
    check("run pc0", sp(0), 32'h0);
    check("run pc1", sp(1), 32'h4);
    check("run pc2", sp(2), 32'h8);
    check("run ins0", si(0), mem_word(32'h0));
    check("run ins2", si(2), mem_word(32'h8));
    check("run gap01", sc(1) - sc(0), 32'd2);
    check("run gap12", sc(2) - sc(1), 32'd2);

    // decode stall fills the buffer, then drains
    do_reset(1);
    id_ready = 1'b0;
    step(10);
    @(negedge clk);
    check("stall next_pc", next_pc_out, 32'h8);
    check("stall req_valid", imem_req_valid, 32'h0);
    check("stall id_valid", id_valid, 32'h1);
    check("stall id_pc", id_pc, 32'h0);
    check("stall fires", nfire, 32'd2);
    #1 id_ready = 1'b1;
    step(8);
    check("drain pc0", sp(0), 32'h0);
    check("drain pc1", sp(1), 32'h4);
    check("drain pc2", sp(2), 32'h8);
    check("drain gap", sc(1) - sc(0), 32'd1);

    // redirect during WAIT, stale response arrives later
    do_reset(4);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    check("rdw next_pc", next_pc_out, 32'h100);
    check("rdw req_valid", imem_req_valid, 32'h0);
    step(1);
    redirect_valid = 1'b0;
    step(14);
    check("rdw pc0", sp(0), 32'h100);
    check("rdw ins0", si(0), mem_word(32'h100));
    check("rdw pc1", sp(1), 32'h104);
    check("rdw stale", n_low(), 32'd0);

    // redirect coincident with response and decode ready
    do_reset(1);
    id_ready = 1'b0;
    step(3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    id_ready       = 1'b1;
    @(negedge clk);
    check("rdr id_valid", id_valid, 32'h1);
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rdr flushed", id_valid, 32'h0);
    check("rdr req_valid", imem_req_valid, 32'h1);
    check("rdr req_addr", imem_req_addr, 32'h200);
    step(6);
    check("rdr pc0", sp(0), 32'h200);

    // address wrap on accept
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("wrap addr", imem_req_addr, 32'hFFFF_FFFC);
    check("wrap next_pc", next_pc_out, 32'h0);
    step(8);
    check("wrap pc0", sp(0), 32'hFFFF_FFFC);
    check("wrap pc1", sp(1), 32'h0);

    // misaligned redirect
    do_reset(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
`ifdef FETCH_MISALIGN_CHK_EN
    @(negedge clk);
    check("mis next_pc", next_pc_out, 32'h102);
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("mis fault", fetch_fault, 32'h1);
    check("mis req_valid", imem_req_valid, 32'h0);
    step(4);
    check("mis fires", nfire, 32'd0);
    check("mis fault held", fetch_fault, 32'h1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("mis clear", fetch_fault, 32'h0);
    check("mis req_valid2", imem_req_valid, 32'h1);
    check("mis req_addr", imem_req_addr, 32'h200);
    step(6);
    check("mis pc0", sp(0), 32'h200);
`else
    @(negedge clk);
    check("mis next_pc", next_pc_out, 32'h100);
    step(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    check("mis fault", fetch_fault, 32'h0);
    check("mis req_valid", imem_req_valid, 32'h1);
    check("mis req_addr", imem_req_addr, 32'h100);
    step(6);
    check("mis pc0", sp(0), 32'h100);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
